buffer_route_scheduler: RTL and testbench

- Control stage directly upstream of the buffer interconnect; generates its module_select and slot_select vectors.
- Accepts route requests: write routes (module -> slot) and read routes (slot -> module), each with a beat length.
- Holds each select stable for the whole transfer plus the interconnect pipeline depth, then releases the route.
- Reports completions one per cycle to the FHE ALU controller.

---
 rtl/buffer_route_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_buffer_route_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/buffer_route_scheduler.sv
// Route scheduler driving module_select/slot_select of the buffer interconnect.
// Define ROUTE_STATS_EN to build the saturating accept/stall counters.
module buffer_route_tracker #(
    parameter int LEN_W        = 16,
    parameter int DRAIN_CYCLES = 4,
    parameter int SEL_W        = 3,
    parameter int IDLE_SEL     = 0,
    parameter bit HOLD_IDLE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             fin_o,
    output logic [SEL_W-1:0] sel_o
);
    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [1:0] ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_DRAIN = 2'd2;
    localparam logic [SEL_W-1:0] IDLE_V = SEL_W'(IDLE_SEL);
    localparam logic [SEL_W-1:0] RST_V  = HOLD_IDLE ? '0 : IDLE_V;

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dcnt_q, dcnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = dcnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                state_d = ST_ACTIVE;
                cnt_d   = len_i;
                sel_d   = sel_i;
            end
            ST_ACTIVE: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    if (DRAIN_CYCLES == 0) state_d = ST_IDLE;
                    else begin
                        state_d = ST_DRAIN;
                        dcnt_d  = DW'(DRAIN_CYCLES);
                    end
                end
            end
            ST_DRAIN: begin
                dcnt_d = dcnt_q - DW'(1);
                if (dcnt_q == DW'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // non-power-of-two counts park the select on the zero-tied input
        if (state_q != ST_IDLE && state_d == ST_IDLE && !HOLD_IDLE) sel_d = IDLE_V;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            sel_q   <= RST_V;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            sel_q   <= sel_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign fin_o  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
    assign sel_o  = sel_q;
endmodule

module buffer_route_scheduler #(
    parameter int SLOT_NUM     = 8,
    parameter int MODULE_NUM   = 6,
    parameter int DRAIN_CYCLES = 4,
    parameter int LEN_W        = 16,
    localparam int MW = $clog2(MODULE_NUM),
    localparam int SW = $clog2(SLOT_NUM),
    localparam int IW = $clog2((SLOT_NUM > MODULE_NUM) ? SLOT_NUM : MODULE_NUM)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_dir,
    input  logic [MW-1:0]                 req_module,
    input  logic [SW-1:0]                 req_slot,
    input  logic [LEN_W-1:0]              req_len,
    output logic [SLOT_NUM-1:0][MW-1:0]   module_select,
    output logic [MODULE_NUM-1:0][SW-1:0] slot_select,
    output logic [SLOT_NUM-1:0]           slot_wr_busy,
    output logic [MODULE_NUM-1:0]         module_rd_busy,
    output logic                          done_valid,
    output logic                          done_dir,
    output logic [IW-1:0]                 done_id,
    output logic                          err,
    output logic [31:0]                   stat_accept,
    output logic [31:0]                   stat_stall
);
    localparam int  PN     = SLOT_NUM + MODULE_NUM;
    localparam bit  M_POW2 = (MODULE_NUM & (MODULE_NUM - 1)) == 0;
    localparam bit  S_POW2 = (SLOT_NUM & (SLOT_NUM - 1)) == 0;

    logic [2**SW-1:0]     wr_busy_ext;
    logic [2**MW-1:0]     rd_busy_ext;
    logic                 oor, illegal, hs, err_q;
    logic [SLOT_NUM-1:0]  wr_fin;
    logic [MODULE_NUM-1:0] rd_fin;
    logic [PN-1:0]        pend_q, pend_d, issue;

    assign wr_busy_ext = (2**SW)'(slot_wr_busy);
    assign rd_busy_ext = (2**MW)'(module_rd_busy);
    assign oor       = (32'(req_module) >= MODULE_NUM) || (32'(req_slot) >= SLOT_NUM);
    assign illegal   = oor || (req_len == '0);
    assign req_ready = oor ? 1'b1 : (req_dir ? !rd_busy_ext[req_module] : !wr_busy_ext[req_slot]);
    assign hs        = req_valid && req_ready;

    for (genvar s = 0; s < SLOT_NUM; s++) begin : g_wr
        buffer_route_tracker #(
            .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN_CYCLES), .SEL_W(MW),
            .IDLE_SEL(MODULE_NUM), .HOLD_IDLE(M_POW2)
        ) u_trk (
            .clk(clk), .rst(rst),
            .start_i(hs && !illegal && !req_dir && (32'(req_slot) == s)),
            .sel_i(req_module), .len_i(req_len),
            .busy_o(slot_wr_busy[s]), .fin_o(wr_fin[s]), .sel_o(module_select[s])
        );
    end

    for (genvar m = 0; m < MODULE_NUM; m++) begin : g_rd
        buffer_route_tracker #(
            .LEN_W(LEN_W), .DRAIN_CYCLES(DRAIN_CYCLES), .SEL_W(SW),
            .IDLE_SEL(SLOT_NUM), .HOLD_IDLE(S_POW2)
        ) u_trk (
            .clk(clk), .rst(rst),
            .start_i(hs && !illegal && req_dir && (32'(req_module) == m)),
            .sel_i(req_slot), .len_i(req_len),
            .busy_o(module_rd_busy[m]), .fin_o(rd_fin[m]), .sel_o(slot_select[m])
        );
    end

    // write bits occupy the low end, so lowest-set-bit gives write-first order
    always_comb begin
        int idx;
        idx        = 0;
        issue      = pend_q & (~pend_q + PN'(1));
        for (int i = PN - 1; i >= 0; i--) if (pend_q[i]) idx = i;
        done_valid = |pend_q;
        done_dir   = (idx >= SLOT_NUM);
        done_id    = done_dir ? IW'(idx - SLOT_NUM) : IW'(idx);
        pend_d     = (pend_q & ~issue) | {rd_fin, wr_fin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            err_q  <= hs && illegal;
        end
    end
    assign err = err_q;

`ifdef ROUTE_STATS_EN
    logic [31:0] acc_q, stl_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            stl_q <= '0;
        end else begin
            if (hs && acc_q != '1) acc_q <= acc_q + 32'd1;
            if (req_valid && !req_ready && stl_q != '1) stl_q <= stl_q + 32'd1;
        end
    end
    assign stat_accept = acc_q;
    assign stat_stall  = stl_q;
`else
    assign stat_accept = '0;
    assign stat_stall  = '0;
`endif
endmodule

// File: tb/tb_buffer_route_scheduler.sv
// Bench for buffer_route_scheduler: directed steps plus random traffic against a timing model.
module tb_buffer_route_scheduler;
    localparam int SN = 8, MN = 6, D = 4, LW = 16;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic rv, rdir;
    logic [2:0] rmod, rslot;
    logic [LW-1:0] rlen;
    logic req_ready, done_valid, done_dir, err;
    logic [SN-1:0][2:0] module_select;
    logic [MN-1:0][2:0] slot_select;
    logic [SN-1:0] slot_wr_busy;
    logic [MN-1:0] module_rd_busy;
    logic [2:0] done_id;
    logic [31:0] stat_accept, stat_stall;

    buffer_route_scheduler #(.SLOT_NUM(SN), .MODULE_NUM(MN), .DRAIN_CYCLES(D), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .req_valid(rv), .req_ready(req_ready), .req_dir(rdir),
        .req_module(rmod), .req_slot(rslot), .req_len(rlen),
        .module_select(module_select), .slot_select(slot_select),
        .slot_wr_busy(slot_wr_busy), .module_rd_busy(module_rd_busy),
        .done_valid(done_valid), .done_dir(done_dir), .done_id(done_id), .err(err),
        .stat_accept(stat_accept), .stat_stall(stat_stall)
    );

    // Model: a route accepted in cycle T owns its tracker until cycle T+1+len+D.
    int  wr_end[SN], wr_sel[SN], rd_end[MN], rd_sel[MN];
    bit  pend[SN+MN];
    bit  err_e;
    int  acc, stl, cyc, total, bad;

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SN; i++) begin wr_end[i] = 0; wr_sel[i] = 0; end
        for (int i = 0; i < MN; i++) begin rd_end[i] = 0; rd_sel[i] = 0; end
        for (int i = 0; i < SN + MN; i++) pend[i] = 0;
        err_e = 0; acc = 0; stl = 0;
    endtask

    function automatic bit model_ready();
        if (int'(rmod) >= MN) return 1'b1;
        if (rdir) return !(cyc < rd_end[rmod]);
        return !(cyc < wr_end[rslot]);
    endfunction

    function automatic int first_pend();
        int f = -1;
        for (int i = SN + MN - 1; i >= 0; i--) if (pend[i]) f = i;
        return f;
    endfunction

    task automatic check_outputs();
        logic [SN-1:0] eb;
        logic [MN-1:0] erb;
        logic [SN-1:0][2:0] ems;
        logic [MN-1:0][2:0] ess;
        int f;
        for (int s = 0; s < SN; s++) begin
            eb[s]  = cyc < wr_end[s];
            ems[s] = eb[s] ? 3'(wr_sel[s]) : 3'(MN);
        end
        for (int m = 0; m < MN; m++) begin
            erb[m] = cyc < rd_end[m];
            ess[m] = 3'(rd_sel[m]);
        end
        chk("slot_wr_busy", slot_wr_busy, eb);
        chk("module_rd_busy", module_rd_busy, erb);
        chk("module_select", module_select, ems);
        chk("slot_select", slot_select, ess);
        chk("req_ready", req_ready, model_ready());
        chk("err", err, err_e);
        f = first_pend();
        chk("done_valid", done_valid, f >= 0);
        if (f >= 0) begin
            chk("done_dir", done_dir, f >= SN);
            chk("done_id", done_id, (f >= SN) ? f - SN : f);
        end
`ifdef ROUTE_STATS_EN
        chk("stat_accept", stat_accept, acc);
        chk("stat_stall", stat_stall, stl);
`else
        chk("stat_accept", stat_accept, 0);
        chk("stat_stall", stat_stall, 0);
`endif
    endtask

    task automatic model_edge(input bit hs);
        int nc = cyc + 1;
        int f  = first_pend();
        if (f >= 0) pend[f] = 0;
        for (int s = 0; s < SN; s++) if (wr_end[s] == nc) pend[s] = 1;
        for (int m = 0; m < MN; m++) if (rd_end[m] == nc) pend[SN+m] = 1;
        err_e = 0;
        if (rv && !hs) stl++;
        if (hs) begin
            acc++;
            if (int'(rmod) >= MN || rlen == 0) err_e = 1;
            else if (!rdir) begin wr_end[rslot] = nc + int'(rlen) + D; wr_sel[rslot] = rmod; end
            else begin rd_end[rmod] = nc + int'(rlen) + D; rd_sel[rmod] = rslot; end
        end
    endtask

    task automatic step(output bit hs);
        @(negedge clk);
        check_outputs();
        hs = rv && model_ready();
        model_edge(hs);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        bit h;
        rv = 0;
        repeat (n) step(h);
    endtask

    task automatic req(input bit dir, input int m, input int s, input int len, output bit hs);
        rv = 1; rdir = dir; rmod = 3'(m); rslot = 3'(s); rlen = LW'(len);
        step(hs);
        rv = 0;
    endtask

    initial begin
        bit h;
        int n;
        total = 0; bad = 0; cyc = 0;
        rv = 0; rdir = 0; rmod = 0; rslot = 0; rlen = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 0;

        idle(10);
        req(0, 2, 5, 3, h);          chk("wr_m2_s5_accept", h, 1);
        idle(12);

        req(1, 0, 1, 1, h);          chk("rd_m0_accept", h, 1);
        rv = 1; rdir = 1; rmod = 0; rslot = 2; rlen = 1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(h);
            if (h) break;
            n++;
        end
        rv = 0;
        chk("rd_stall_accepted", h, 1);
        chk("rd_stall_cycles", n, 1 + D);
        idle(10);

        req(0, 0, 3, 4, h);          chk("wr_s3_accept", h, 1);
        req(0, 1, 1, 3, h);          chk("wr_s1_accept", h, 1);
        req(1, 4, 0, 2, h);          chk("rd_m4_accept", h, 1);
        idle(14);

        req(0, 7, 2, 5, h);          chk("illegal_module_accept", h, 1);
        idle(3);
        req(0, 1, 0, 0, h);          chk("illegal_len0_accept", h, 1);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            rv    = ($urandom_range(0, 9) < 6);
            rdir  = 1'($urandom);
            rmod  = 3'($urandom_range(0, (i % 17 == 0) ? 7 : MN - 1));
            rslot = 3'($urandom_range(0, SN - 1));
            rlen  = (i % 23 == 0) ? '0 : LW'($urandom_range(1, 8));
            step(h);
        end
        idle(20);

        req(0, 1, 2, 100, h);        chk("long_wr_accept", h, 1);
        idle(5);
        rv = 1; rdir = 0; rmod = 3; rslot = 2; rlen = 2;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_wr_busy", slot_wr_busy, '0);
        chk("rst_rd_busy", module_rd_busy, '0);
        chk("rst_module_select", module_select, {SN{3'(MN)}});
        chk("rst_slot_select", slot_select, '0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_ready", req_ready, 1);
        model_reset();
        @(posedge clk);
        #1 rst = 0;
        step(h);                     chk("post_rst_accept", h, 1);
        rv = 0;
        idle(130);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
